mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-client memory arbiter directly downstream of the instruction cache and data cache.
- Merges their line-granular memory requests onto the single shared memory port.
- Each transaction runs to completion; the memory ready is routed back only to the owning cache.
- Round-robin fairness when both caches miss in the same cycle, so an instruction-fetch miss storm cannot starve data traffic, and vice versa.

Parameters:
- ADDR_W, 28, line address width (word address minus 2 offset bits).
- DATA_W, 128, line width in bits.

Ports:
- clk  in  1  system clock, rising edge.
- proc_reset_n  in  1  asynchronous, active-low reset.
- i_read  in  1  I-cache line read request; held until i_ready.
- i_addr  in  ADDR_W  I-cache line address.
- i_rdata  out  DATA_W  line data to I-cache.
- i_ready  out  1  I-cache transaction complete, one cycle.
- d_read  in  1  D-cache line read request; held until d_ready.
- d_write  in  1  D-cache line write-back request; held until d_ready.
- d_addr  in  ADDR_W  D-cache line address.
- d_wdata  in  DATA_W  D-cache write-back data.
- d_rdata  out  DATA_W  line data to D-cache.
- d_ready  out  1  D-cache transaction complete, one cycle.
- mem_read  out  1  memory read strobe, registered.
- mem_write  out  1  memory write strobe, registered.
- mem_addr  out  ADDR_W  memory line address, registered.
- mem_wdata  out  DATA_W  memory write data, registered.
- mem_rdata  in  DATA_W  memory read data, valid when mem_ready.
- mem_ready  in  1  memory transaction complete, one cycle.

Behaviour:
- States: IDLE, GRANT_I, GRANT_D. A 1-bit last_grant register (0 = I, 1 = D) drives round-robin.
- Reset (asynchronous, proc_reset_n=0):
  - state=IDLE, last_grant=1 (so I wins the first tie).
  - mem_read=mem_write=0, mem_addr=0, mem_wdata=0.
  - i_ready=d_ready=0.
  - i_rdata and d_rdata follow mem_rdata; they are don't-care when the matching ready is 0.
- Reset asserted mid-transaction aborts it immediately: strobes drop without waiting for mem_ready. The memory model must ignore a stale mem_ready after reset.
- IDLE:
  - d_pend = d_read|d_write; i_pend = i_read.
  - Only one pending: grant it.
  - Both pending: grant the client opposite last_grant.
  - On grant, at the clock edge:
    - latch the client address into mem_addr.
    - I grant: mem_read=1.
    - D grant: mem_write=d_write, mem_read=d_read&~d_write, mem_wdata=d_wdata.
    - last_grant updated; state goes to GRANT_I or GRANT_D.
- D client with d_read and d_write both high: the write is served first. The read stays pending and competes in the next arbitration.
- GRANT_x:
  - Registered mem_* outputs are held stable; client inputs are not re-sampled.
  - In the cycle mem_ready=1, x_ready=1 combinationally and x_rdata=mem_rdata (pass-through, same cycle).
  - The other client's ready stays 0.
  - On that edge: state returns to IDLE and mem_read/mem_write clear.
- mem_ready in IDLE is ignored: neither ready is asserted.
- Latency:
  - Request first seen in IDLE at edge T: mem strobe visible from T+1.
  - Earliest completion: mem_ready in cycle T+1, so the client sees ready one cycle after raising its request.
  - Back-to-back: the arbiter spends at least one IDLE cycle between transactions, so the minimum gap is 1 cycle of no strobe.
- A client dropping its request while granted does not abort the transaction. The memory access completes and ready is still pulsed to that client.
- A request that rises in the same cycle its partner's ready pulses is arbitrated in the following IDLE cycle.
- No combinational path exists from client inputs to mem_* outputs. The only combinational paths are mem_ready/mem_rdata to x_ready/x_rdata.

Test Plan:
- Reset then single I miss: i_read=1, i_addr=28'h0000123, memory ready after 3 cycles with mem_rdata=128'hA5.. -> mem_read=1 and mem_addr=28'h0000123 from next cycle; i_ready pulses once with i_rdata=128'hA5..; d_ready stays 0; mem_read=0 the cycle after.
- Simultaneous misses after reset: i_read=1 and d_read=1 in the same cycle -> I granted first (last_grant reset=1), then D. A further tie grants I; repeated ties alternate I, D, I, D.
- D write-back then read: d_write=1, d_read=1, d_addr=28'h00000AB, d_wdata=128'h1234.. -> first transaction mem_write=1, mem_read=0, mem_wdata=128'h1234..; after d_ready, second transaction mem_read=1 on the same address.
- Stray/early ready: mem_ready=1 while IDLE -> i_ready=d_ready=0 and no state change. Client drops i_read mid-grant -> mem_read held; i_ready still pulses on mem_ready.
- Asynchronous reset mid-transaction: proc_reset_n=0 between clock edges during GRANT_D with mem_write=1 -> mem_write=0 immediately. After release, a new I request is granted normally.
- Zero-wait memory: mem_ready tied high -> each request completes one cycle after strobe assertion, with one idle cycle between back-to-back transactions.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-client line arbiter between the I-cache/D-cache and one shared memory port.
// Whole transactions are granted round-robin on ties. The memory ready and read data are routed back to the owner.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              proc_reset_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t            state_q;
    logic              last_grant_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic              i_pend_s;
    logic              d_pend_s;
    logic              grant_d_s;

    // Arbitration decision: a tie goes to the client opposite the last grant
    always_comb begin
        i_pend_s = i_read;
        d_pend_s = d_read | d_write;
        if (i_pend_s && d_pend_s) begin
            grant_d_s = ~last_grant_q;
        end else begin
            grant_d_s = d_pend_s;
        end
    end

    // Grant FSM with registered memory-side strobes, address and write data
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= {ADDR_W{1'b0}};
            mem_wdata_q  <= {DATA_W{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_pend_s || d_pend_s) begin
                        if (grant_d_s) begin
                            // A combined read+write-back serves the write first
                            mem_addr_q   <= d_addr;
                            mem_wdata_q  <= d_wdata;
                            mem_write_q  <= d_write;
                            mem_read_q   <= d_read & ~d_write;
                            last_grant_q <= 1'b1;
                            state_q      <= GRANT_D;
                        end else begin
                            mem_addr_q   <= i_addr;
                            mem_write_q  <= 1'b0;
                            mem_read_q   <= 1'b1;
                            last_grant_q <= 1'b0;
                            state_q      <= GRANT_I;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (mem_ready) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        state_q <= state_q;
                    end
                end
                default: begin
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Completion is a same-cycle pass-through to the owning client only
    assign i_ready = mem_ready & (state_q == GRANT_I);
    assign d_ready = mem_ready & (state_q == GRANT_D);
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a cycle vector table, directed corner sequences,
// and randomized client/memory traffic checked against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          proc_reset_n = 1'b0;
    logic          i_read = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_rdata;
    logic          i_ready;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .proc_reset_n(proc_reset_n),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        proc_reset_n = 1'b0;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_ready = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #2 proc_reset_n = 1'b1;
    endtask

    typedef struct packed {
        logic          ir;
        logic          drd;
        logic          dwr;
        logic          mrdy;
        logic          e_mr;
        logic          e_mw;
        logic          e_ir;
        logic          e_dr;
        logic [AW-1:0] e_addr;
    } vec_t;

    vec_t vecs [9];

    // transaction-level reference state
    int            owner;
    logic          tie_d;
    logic          t_wr;
    logic          pick_d;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          i_done;
    logic          d_done;
    logic [DW-1:0] pat_a5;
    logic [DW-1:0] pat_12;

    initial begin
        pat_a5 = {16{8'hA5}};
        pat_12 = {8{16'h1234}};

        // reset state, with a stray mem_ready present
        mem_ready = 1'b1;
        #3;
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        chk("rst_i_ready", i_ready, 1'b0);
        chk("rst_d_ready", d_ready, 1'b0);

        // tie alternation table: both clients always requesting reads
        vecs[0] = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 28'h0000000};
        vecs[1] = {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 28'h0000123};
        vecs[2] = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 28'h0000123};
        vecs[3] = {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 28'h00000AB};
        vecs[4] = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 28'h00000AB};
        vecs[5] = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 28'h0000123};
        vecs[6] = {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 28'h0000123};
        vecs[7] = {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 28'h0000123};
        vecs[8] = {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 28'h00000AB};

        do_reset();
        i_addr = 28'h0000123;
        d_addr = 28'h00000AB;
        for (int k = 0; k < 9; k++) begin
            cyc();
            i_read = vecs[k].ir; d_read = vecs[k].drd; d_write = vecs[k].dwr;
            mem_ready = vecs[k].mrdy;
            smp();
            chk($sformatf("vec%0d_mem_read", k), mem_read, vecs[k].e_mr);
            chk($sformatf("vec%0d_mem_write", k), mem_write, vecs[k].e_mw);
            chk($sformatf("vec%0d_i_ready", k), i_ready, vecs[k].e_ir);
            chk($sformatf("vec%0d_d_ready", k), d_ready, vecs[k].e_dr);
            chk($sformatf("vec%0d_mem_addr", k), mem_addr, vecs[k].e_addr);
        end

        // single I miss with 3-cycle memory
        do_reset();
        cyc(); i_read = 1'b1; i_addr = 28'h0000123;
        smp(); chk("imiss_idle_read", mem_read, 1'b0);
        cyc(); smp();
        chk("imiss_strobe", mem_read, 1'b1);
        chk("imiss_addr", mem_addr, 28'h0000123);
        chk("imiss_early_ready", i_ready, 1'b0);
        cyc(); smp();
        cyc(); mem_ready = 1'b1; mem_rdata = pat_a5;
        smp();
        chk("imiss_i_ready", i_ready, 1'b1);
        chk("imiss_i_rdata", i_rdata, pat_a5);
        chk("imiss_d_ready", d_ready, 1'b0);
        cyc(); i_read = 1'b0; mem_ready = 1'b0;
        smp();
        chk("imiss_read_clear", mem_read, 1'b0);
        chk("imiss_ready_once", i_ready, 1'b0);

        // D write-back and read together: write first, then read on same address
        cyc(); d_write = 1'b1; d_read = 1'b1; d_addr = 28'h00000AB; d_wdata = pat_12;
        smp();
        cyc(); mem_ready = 1'b1;
        smp();
        chk("wb_write", mem_write, 1'b1);
        chk("wb_no_read", mem_read, 1'b0);
        chk("wb_wdata", mem_wdata, pat_12);
        chk("wb_addr", mem_addr, 28'h00000AB);
        chk("wb_d_ready", d_ready, 1'b1);
        cyc(); d_write = 1'b0; mem_ready = 1'b0;
        smp();
        chk("wb_gap_write", mem_write, 1'b0);
        chk("wb_gap_read", mem_read, 1'b0);
        cyc(); mem_ready = 1'b1; mem_rdata = {4{32'hDEADBEEF}};
        smp();
        chk("rd_read", mem_read, 1'b1);
        chk("rd_no_write", mem_write, 1'b0);
        chk("rd_addr", mem_addr, 28'h00000AB);
        chk("rd_d_ready", d_ready, 1'b1);
        chk("rd_d_rdata", d_rdata, {4{32'hDEADBEEF}});
        cyc(); d_read = 1'b0; mem_ready = 1'b0;
        smp();
        chk("rd_clear", mem_read, 1'b0);

        // stray ready in IDLE, then client drops request mid-grant
        cyc(); mem_ready = 1'b1;
        smp();
        chk("stray_i_ready", i_ready, 1'b0);
        chk("stray_d_ready", d_ready, 1'b0);
        cyc(); mem_ready = 1'b0; i_read = 1'b1; i_addr = 28'h0000777;
        smp();
        chk("stray_no_state_change", mem_read, 1'b0);
        cyc(); i_read = 1'b0;
        smp();
        chk("drop_read_held", mem_read, 1'b1);
        chk("drop_addr_held", mem_addr, 28'h0000777);
        cyc(); smp();
        chk("drop_read_held2", mem_read, 1'b1);
        cyc(); mem_ready = 1'b1;
        smp();
        chk("drop_i_ready", i_ready, 1'b1);
        cyc(); mem_ready = 1'b0;
        smp();
        chk("drop_clear", mem_read, 1'b0);

        // asynchronous reset during a D write-back
        cyc(); d_write = 1'b1; d_addr = 28'h00000AB; d_wdata = pat_12;
        smp();
        cyc(); smp();
        chk("areset_pre_write", mem_write, 1'b1);
        #2 proc_reset_n = 1'b0;
        #1;
        chk("areset_write_drop", mem_write, 1'b0);
        chk("areset_read_drop", mem_read, 1'b0);
        chk("areset_addr", mem_addr, '0);
        mem_ready = 1'b1; d_write = 1'b0;
        #1;
        chk("areset_stale_d_ready", d_ready, 1'b0);
        @(posedge clk);
        #2 proc_reset_n = 1'b1;
        i_read = 1'b1; i_addr = 28'h0000055;
        smp();
        chk("areset_stale_i_ready", i_ready, 1'b0);
        chk("areset_idle_read", mem_read, 1'b0);
        cyc(); mem_ready = 1'b0;
        smp();
        chk("areset_new_read", mem_read, 1'b1);
        chk("areset_new_addr", mem_addr, 28'h0000055);
        cyc(); mem_ready = 1'b1;
        smp();
        chk("areset_new_ready", i_ready, 1'b1);
        cyc(); i_read = 1'b0; mem_ready = 1'b0;
        smp();

        // zero-wait memory: strobe every other cycle with an idle cycle between
        cyc(); mem_ready = 1'b1; i_read = 1'b1; i_addr = 28'h000003C;
        for (int k = 0; k < 6; k++) begin
            smp();
            chk($sformatf("zw%0d_mem_read", k), mem_read, (k % 2 == 1) ? 1'b1 : 1'b0);
            chk($sformatf("zw%0d_i_ready", k), i_ready, (k % 2 == 1) ? 1'b1 : 1'b0);
            cyc();
        end
        i_read = 1'b0; mem_ready = 1'b0;

        // randomized traffic against the transaction-level model
        do_reset();
        owner = 0; tie_d = 1'b0; t_wr = 1'b0; m_addr = '0; m_wdata = '0;
        i_done = 1'b0; d_done = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            cyc();
            if (i_done) begin i_read = 1'b0; i_done = 1'b0; end
            if (d_done) begin
                if (d_write) d_write = 1'b0;
                else d_read = 1'b0;
                d_done = 1'b0;
            end
            if (!i_read && $urandom_range(0, 3) == 0) begin
                i_read = 1'b1;
                i_addr = AW'($urandom);
            end
            if (!d_read && !d_write && $urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                    0: begin d_read = 1'b1; d_write = 1'b0; end
                    1: begin d_read = 1'b0; d_write = 1'b1; end
                    default: begin d_read = 1'b1; d_write = 1'b1; end
                endcase
                d_addr = AW'($urandom);
                d_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            mem_ready = ($urandom_range(0, 2) == 0);
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            smp();
            chk("rnd_mem_read", mem_read, (owner != 0) && !t_wr);
            chk("rnd_mem_write", mem_write, (owner != 0) && t_wr);
            chk("rnd_mem_addr", mem_addr, m_addr);
            chk("rnd_mem_wdata", mem_wdata, m_wdata);
            chk("rnd_i_ready", i_ready, (owner == 1) && mem_ready);
            chk("rnd_d_ready", d_ready, (owner == 2) && mem_ready);
            if (owner == 1 && mem_ready) chk("rnd_i_rdata", i_rdata, mem_rdata);
            if (owner == 2 && mem_ready) chk("rnd_d_rdata", d_rdata, mem_rdata);
            if (owner != 0) begin
                if (mem_ready) begin
                    if (owner == 1) i_done = 1'b1;
                    else d_done = 1'b1;
                    owner = 0;
                end
            end else if (i_read || d_read || d_write) begin
                if (i_read && (d_read || d_write)) pick_d = tie_d;
                else pick_d = !i_read;
                if (pick_d) begin
                    owner = 2; m_addr = d_addr; m_wdata = d_wdata; t_wr = d_write; tie_d = 1'b0;
                end else begin
                    owner = 1; m_addr = i_addr; t_wr = 1'b0; tie_d = 1'b1;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
